// File: rtl/window_filter_3x3.sv
// 3x3 neighbourhood filter: window shift registers plus a two-stage
// arithmetic pipeline with pass, Gaussian, Sobel and sharpen kernels.
`timescale 1ns/1ps
module window_filter_3x3 #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pixel_valid,
    input  logic                  frame_start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] line0,
    input  logic [DATA_WIDTH-1:0] line1,
    input  logic [DATA_WIDTH-1:0] line2,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  out_valid
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int GW = DW + 4;
    localparam int SW = DW + 3;
    localparam int HW = DW + 4;
    localparam logic [DW-1:0] MAX = {DW{1'b1}};

    logic [DW-1:0] p [3][3];
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          pix_edge;

    logic          w_valid, w_edge;
    logic [1:0]    w_mode;

    logic [GW-1:0]        g_sum;
    logic [SW-1:0]        gx_p, gx_n, gy_p, gy_n;
    logic signed [SW-1:0] gx, gy;
    logic [SW-1:0]        ax, ay, s_sum;
    logic signed [HW-1:0] sh;

    logic                 a_valid, a_edge;
    logic [1:0]           a_mode;
    logic [DW-1:0]        a_p11, a_gauss;
    logic [SW-1:0]        a_sobel;
    logic signed [HW-1:0] a_sharp;
    logic [DW-1:0]        res;

    // position of the pixel being accepted; frame_start forces (0,0)
    always_comb begin
        cur_col  = frame_start ? '0 : col;
        cur_row  = frame_start ? '0 : row;
        pix_edge = (cur_row < RW'(2)) || (cur_col < CW'(2));
    end

    // shift the new column into the right-hand side of the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    p[i][j] <= '0;
        end else if (pixel_valid) begin
            for (int i = 0; i < 3; i++) begin
                p[i][0] <= p[i][1];
                p[i][1] <= p[i][2];
            end
            p[0][2] <= line0;
            p[1][2] <= line1;
            p[2][2] <= line2;
        end
    end

    // column/row counters point at the next pixel to arrive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (pixel_valid) begin
            if (cur_col == CW'(WIDTH - 1)) begin
                col <= '0;
                row <= (cur_row == RW'(HEIGHT - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // side-band flags travelling with the window contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid <= 1'b0;
            w_edge  <= 1'b0;
            w_mode  <= '0;
        end else begin
            w_valid <= pixel_valid;
            if (pixel_valid) begin
                w_edge <= pix_edge;
                w_mode <= mode;
            end
        end
    end

    // kernel sums over the current window
    always_comb begin
        g_sum = GW'(p[0][0]) + (GW'(p[0][1]) << 1) + GW'(p[0][2])
              + (GW'(p[1][0]) << 1) + (GW'(p[1][1]) << 2)
              + (GW'(p[1][2]) << 1) + GW'(p[2][0])
              + (GW'(p[2][1]) << 1) + GW'(p[2][2]) + GW'(8);
        gx_p  = SW'(p[0][2]) + (SW'(p[1][2]) << 1) + SW'(p[2][2]);
        gx_n  = SW'(p[0][0]) + (SW'(p[1][0]) << 1) + SW'(p[2][0]);
        gy_p  = SW'(p[2][0]) + (SW'(p[2][1]) << 1) + SW'(p[2][2]);
        gy_n  = SW'(p[0][0]) + (SW'(p[0][1]) << 1) + SW'(p[0][2]);
        gx    = $signed(gx_p - gx_n);
        gy    = $signed(gy_p - gy_n);
        ax    = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay    = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
        s_sum = ax + ay;
        sh    = $signed((HW'(p[1][1]) << 2) + HW'(p[1][1])
              - (HW'(p[0][1]) + HW'(p[1][0])
              + HW'(p[1][2]) + HW'(p[2][1])));
    end

    // stage A: capture sums and per-pixel mode/edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_edge  <= 1'b0;
            a_mode  <= '0;
            a_p11   <= '0;
            a_gauss <= '0;
            a_sobel <= '0;
            a_sharp <= '0;
        end else begin
            a_valid <= w_valid;
            if (w_valid) begin
                a_edge  <= w_edge;
                a_mode  <= w_mode;
                a_p11   <= p[1][1];
                a_gauss <= DW'(g_sum >> 4);
                a_sobel <= s_sum;
                a_sharp <= sh;
            end
        end
    end

    // clamp and select the kernel result; border pixels are forced to 0
    always_comb begin
        res = '0;
        case (a_mode)
            2'd0: res = a_p11;
            2'd1: res = a_gauss;
            2'd2: res = (a_sobel > SW'(MAX)) ? MAX : a_sobel[DW-1:0];
            default: begin
                if (a_sharp[HW-1])
                    res = '0;
                else if ($unsigned(a_sharp) > HW'(MAX))
                    res = MAX;
                else
                    res = a_sharp[DW-1:0];
            end
        endcase
        if (a_edge)
            res = '0;
    end

    // stage B: registered output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= a_valid;
            if (a_valid)
                pixel_out <= res;
        end
    end

endmodule

// File: tb/tb_window_filter_3x3.sv
// Scoreboard bench for window_filter_3x3 on an 8x6 frame.
`timescale 1ns/1ps
module tb_window_filter_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pixel_valid;
    logic          frame_start;
    logic [1:0]    mode;
    logic [DW-1:0] line0, line1, line2;
    logic [DW-1:0] pixel_out;
    logic          out_valid;

    window_filter_3x3 #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .reset(reset),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .mode(mode),
        .line0(line0),
        .line1(line1),
        .line2(line2),
        .pixel_out(pixel_out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int r;
        int c;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   tests = 0;
    int   fails = 0;
    int   ov_count = 0;
    int   n0;
    logic [2:0] vhist;
    bit   chk_pat;

    // image generators: 0 flat 100, 1 step at col 4, 2 spot, 3 ramp
    function automatic int pix(int img, int r, int c);
        if (r < 0) return 0;
        case (img)
            0: return 100;
            1: return (c < 4) ? 0 : 255;
            2: return (r == 2 && c == 3) ? 50 : 0;
            default: return (c + 8 * r) & 255;
        endcase
    endfunction

    function automatic int model(int img, int md, int r, int c);
        int w[3][3];
        int gx, gy, s;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = pix(img, r - 2 + i, c - 2 + j);
        case (md)
            0: return w[1][1];
            1: return (w[0][0] + 2*w[0][1] + w[0][2] + 2*w[1][0]
                     + 4*w[1][1] + 2*w[1][2] + w[2][0] + 2*w[2][1]
                     + w[2][2] + 8) >> 4;
            2: begin
                gx = (w[0][2] + 2*w[1][2] + w[2][2])
                   - (w[0][0] + 2*w[1][0] + w[2][0]);
                gy = (w[2][0] + 2*w[2][1] + w[2][2])
                   - (w[0][0] + 2*w[0][1] + w[0][2]);
                s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                return (s > 255) ? 255 : s;
            end
            default: begin
                s = 5*w[1][1] - (w[0][1] + w[1][0] + w[1][2] + w[2][1]);
                return (s < 0) ? 0 : ((s > 255) ? 255 : s);
            end
        endcase
    endfunction

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // one clock of stimulus; gaps carry junk that must be ignored
    task automatic drive(bit v, bit fs, int md, int img, int r, int c);
        exp_t e;
        pixel_valid = v;
        frame_start = fs;
        mode        = 2'(md);
        if (v) begin
            line0 = 8'(pix(img, r - 2, c));
            line1 = 8'(pix(img, r - 1, c));
            line2 = 8'(pix(img, r, c));
            e.e = model(img, md, r, c);
            e.r = r;
            e.c = c;
            q.push_back(e);
        end else begin
            line0 = 8'hAA;
            line1 = 8'h55;
            line2 = 8'hAA;
        end
        @(posedge clk);
        #1;
        vhist = {vhist[1:0], v};
        if (chk_pat)
            check("out_valid_pattern", int'(out_valid), int'(vhist[2]));
    endtask

    task automatic frame(int img, int md, bit fs0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                drive(1'b1, fs0 && r == 0 && c == 0, md, img, r, c);
    endtask

    task automatic drain();
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check("drain_empty", q.size(), 0);
    endtask

    // monitor: every output pulse pops and compares one expectation
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            ov_count++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got pixel_out=%0d, expected none",
                         pixel_out);
            end else begin
                me = q.pop_front();
                check($sformatf("pixel_r%0d_c%0d", me.r, me.c),
                      int'(pixel_out), me.e);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        mode        = 2'd0;
        line0       = '0;
        line1       = '0;
        line2       = '0;
        vhist       = '0;
        chk_pat     = 1'b0;
        #2;
        check("reset_pixel_out", int'(pixel_out), 0);
        check("reset_out_valid", int'(out_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #4 reset = 1'b0;

        // T1: Gaussian of a flat field, latency and pulse count
        vhist   = '0;
        chk_pat = 1'b1;
        n0      = ov_count;
        frame(0, 1, 1'b1);
        chk_pat = 1'b0;
        drain();
        check("t1_pulses", ov_count - n0, 48);

        // T2: Sobel across a vertical step
        frame(1, 2, 1'b1);
        drain();

        // T3: sharpen of a single bright spot
        frame(2, 3, 1'b1);
        drain();

        // T4: pass-through ramp with alternating gaps
        vhist   = '0;
        chk_pat = 1'b1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                drive(1'b1, r == 0 && c == 0, 0, 3, r, c);
                drive(1'b0, 1'b1, 3, 3, r, c);
            end
        chk_pat = 1'b0;
        drain();

        // T5: reset in the middle of row 3
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                drive(1'b1, r == 0 && c == 0, 0, 3, r, c);
        for (int c = 0; c < 5; c++)
            drive(1'b1, 1'b0, 0, 3, 3, c);
        #1 reset = 1'b1;
        q.delete();
        #1;
        check("t5_reset_pixel_out", int'(pixel_out), 0);
        check("t5_reset_out_valid", int'(out_valid), 0);
        #1 reset = 1'b0;
        frame(3, 0, 1'b0);
        drain();

        // T6: frame_start mid-row and a mode switch mid-row
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++)
                drive(1'b1, r == 0 && c == 0, 1, 1, r, c);
        for (int c = 0; c < 5; c++)
            drive(1'b1, 1'b0, 1, 1, 2, c);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                drive(1'b1, r == 0 && c == 0,
                      (r < 2 || (r == 2 && c < 5)) ? 1 : 2, 1, r, c);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
